// File: rtl/set_pkg.sv
// Shared definitions for the SET job scheduler: operand widths, mode codes and FSM states.
package set_pkg;

    localparam int SET_CENT_W = 24;
    localparam int SET_RAD_W  = 12;
    localparam int SET_CAND_W = 8;
    localparam int SET_MODE_W = 2;

    localparam logic [SET_MODE_W-1:0] MODE_A   = 2'b00;
    localparam logic [SET_MODE_W-1:0] MODE_OR  = 2'b01;
    localparam logic [SET_MODE_W-1:0] MODE_XOR = 2'b10;
    localparam logic [SET_MODE_W-1:0] MODE_AND = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/set_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping at NUM_REQ.
module set_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_req_o
);

    int             idx;
    logic [ID_W-1:0] idx_b;

    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        idx         = 0;
        idx_b       = '0;
        // Walk from the farthest offset down so the nearest hit to ptr_i is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_b = ID_W'(idx);
            if (req_i[idx_b]) begin
                grant_o        = '0;
                grant_o[idx_b] = 1'b1;
                grant_idx_o    = idx_b;
                any_req_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_req_scheduler.sv
// Shares one SET engine between NUM_REQ requesters: round-robin grant, start pulse,
// result capture with requester id, and a watchdog that aborts a silent engine.
module set_req_scheduler
    import set_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [SET_CENT_W*NUM_REQ-1:0] req_central,
    input  logic [SET_RAD_W*NUM_REQ-1:0]  req_radius,
    input  logic [SET_MODE_W*NUM_REQ-1:0] req_mode,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [SET_CAND_W-1:0]         rsp_candidate,
    output logic                          rsp_err,
    output logic                          set_en,
    output logic [SET_CENT_W-1:0]         set_central,
    output logic [SET_RAD_W-1:0]          set_radius,
    output logic [SET_MODE_W-1:0]         set_mode,
    input  logic                          set_busy,
    input  logic                          set_valid,
    input  logic [SET_CAND_W-1:0]         set_candidate
);

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [SET_CENT_W-1:0] cent_q, cent_d;
    logic [SET_RAD_W-1:0]  rad_q, rad_d;
    logic [SET_MODE_W-1:0] mode_q, mode_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [SET_CAND_W-1:0] cand_q, cand_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  set_en_q, set_en_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  any_req;

    set_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wdog_d      = wdog_q;
        cent_d      = cent_q;
        rad_d       = rad_q;
        mode_d      = mode_q;
        id_d        = id_q;
        cand_d      = cand_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        set_en_d    = 1'b0;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req && !set_busy) begin
                    req_ready = grant;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            cent_d = req_central[i*SET_CENT_W +: SET_CENT_W];
                            rad_d  = req_radius[i*SET_RAD_W +: SET_RAD_W];
                            mode_d = req_mode[i*SET_MODE_W +: SET_MODE_W];
                        end
                    end
                    id_d = grant_idx;
                    // Explicit wrap keeps rr_ptr legal when NUM_REQ is not a power of two.
                    if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + 1'b1;
                    end
                    set_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (set_valid) begin
                    cand_d      = set_candidate;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_d == WDOG_W'(TIMEOUT - 1)) begin
                    cand_d      = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // An aborted engine may still be running; let it finish before the next start.
                    state_d     = err_q ? ST_DRAIN : ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (!set_busy) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            wdog_q      <= '0;
            cent_q      <= '0;
            rad_q       <= '0;
            mode_q      <= '0;
            id_q        <= '0;
            cand_q      <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            set_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wdog_q      <= wdog_d;
            cent_q      <= cent_d;
            rad_q       <= rad_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            cand_q      <= cand_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            set_en_q    <= set_en_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = id_q;
    assign rsp_candidate = cand_q;
    assign rsp_err       = err_q;
    assign set_en        = set_en_q;
    assign set_central   = cent_q;
    assign set_radius    = rad_q;
    assign set_mode      = mode_q;

endmodule

// File: tb/tb_set_req_scheduler.sv
// Directed bench for set_req_scheduler with a behavioural SET engine that can be switched to a silent stub.
module tb_set_req_scheduler;
    import set_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [SET_CENT_W*NUM_REQ-1:0] req_central;
    logic [SET_RAD_W*NUM_REQ-1:0]  req_radius;
    logic [SET_MODE_W*NUM_REQ-1:0] req_mode;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [SET_CAND_W-1:0]         rsp_candidate;
    logic                          rsp_err;
    logic                          set_en;
    logic [SET_CENT_W-1:0]         set_central;
    logic [SET_RAD_W-1:0]          set_radius;
    logic [SET_MODE_W-1:0]         set_mode;
    logic                          set_busy;
    logic                          set_valid;
    logic [SET_CAND_W-1:0]         set_candidate;

    int n_checks = 0;
    int n_errors = 0;

    bit       stub = 1'b0;
    bit       eng_stub;
    logic [7:0] eng_cnt;

    set_req_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_central   (req_central),
        .req_radius    (req_radius),
        .req_mode      (req_mode),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_candidate (rsp_candidate),
        .rsp_err       (rsp_err),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate)
    );

    always #5 clk = ~clk;

    // Counts 8x8 grid points (1..8) covered by circles A/B combined by mode.
    function automatic int set_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        bit a, b, hit;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                a = ((x - int'(c[23:20])) * (x - int'(c[23:20])) + (y - int'(c[19:16])) * (y - int'(c[19:16])))
                    <= int'(r[11:8]) * int'(r[11:8]);
                b = ((x - int'(c[15:12])) * (x - int'(c[15:12])) + (y - int'(c[11:8])) * (y - int'(c[11:8])))
                    <= int'(r[7:4]) * int'(r[7:4]);
                case (m)
                    2'b00:   hit = a;
                    2'b01:   hit = a | b;
                    2'b10:   hit = a ^ b;
                    default: hit = a & b;
                endcase
                if (hit) n++;
            end
        end
        return n;
    endfunction

    // Engine: busy from start for a few cycles, then a one-cycle valid; the stub stays busy longer and never strobes.
    always @(posedge clk) begin
        set_valid <= 1'b0;
        if (rst) begin
            set_busy      <= 1'b0;
            eng_cnt       <= '0;
            eng_stub      <= 1'b0;
            set_candidate <= '0;
        end else if (set_en) begin
            set_busy      <= 1'b1;
            eng_stub      <= stub;
            eng_cnt       <= stub ? 8'd24 : 8'd4;
            set_candidate <= 8'(set_count(set_central, set_radius, set_mode));
        end else if (set_busy) begin
            if (eng_cnt == 0) begin
                set_busy  <= 1'b0;
                set_valid <= !eng_stub;
            end else begin
                eng_cnt <= eng_cnt - 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with req_valid already driven; returns at the negedge of the set_en cycle.
    task automatic wait_grant(input string tag, input int exp_id);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " grant"}, 32'(req_ready), 32'(1 << exp_id));
        @(negedge clk);
        check({tag, " set_en"}, 32'(set_en), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int exp_id, input int exp_cand, input bit exp_err);
        int n = 0;
        while (!rsp_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, " rsp_candidate"}, 32'(rsp_candidate), 32'(exp_cand));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic accept_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp cleared"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_central[i*SET_CENT_W +: SET_CENT_W] = 24'h440000;
            req_radius[i*SET_RAD_W +: SET_RAD_W]    = 12'h300;
            req_mode[i*SET_MODE_W +: SET_MODE_W]    = MODE_A;
        end
        repeat (3) @(negedge clk);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset set_en", 32'(set_en), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset rsp_candidate", 32'(rsp_candidate), 32'd0);
        check("reset set_central", 32'(set_central), 32'd0);
        check("reset set_radius", 32'(set_radius), 32'd0);
        check("reset set_mode", 32'(set_mode), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Test 1: single job on req0, circle A radius 3 covers 29 points.
        req_valid = 4'b0001;
        wait_grant("t1", 0);
        req_valid = '0;
        check("t1 set_central", 32'(set_central), 32'h440000);
        check("t1 set_radius", 32'(set_radius), 32'h300);
        check("t1 set_mode", 32'(set_mode), 32'd0);
        @(negedge clk);
        check("t1 set_en pulse", 32'(set_en), 32'd0);
        wait_rsp("t1", 0, 29, 1'b0);
        accept_rsp("t1");

        // Test 2: all requesters held valid from rr_ptr=0 -> 0,1,2,3,0.
        pulse_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2", k % NUM_REQ);
            wait_rsp("t2", k % NUM_REQ, 29, 1'b0);
            if (k == 4) req_valid = '0;
            accept_rsp("t2");
        end

        // Test 3: response held under back-pressure, no new grant or start meanwhile.
        req_valid = 4'b0100;
        wait_grant("t3", 2);
        wait_rsp("t3", 2, 29, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("t3 hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("t3 hold rsp_id", 32'(rsp_id), 32'd2);
            check("t3 hold rsp_candidate", 32'(rsp_candidate), 32'd29);
            check("t3 hold req_ready", 32'(req_ready), 32'd0);
            check("t3 hold set_en", 32'(set_en), 32'd0);
        end
        req_valid = '0;
        accept_rsp("t3");

        // Test 4: silent engine, abort lands 16 cycles after the set_en cycle.
        stub      = 1'b1;
        req_valid = 4'b1000;
        wait_grant("t4", 3);
        req_valid = '0;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            check("t4 no early abort", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("t4 abort rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4 abort rsp_err", 32'(rsp_err), 32'd1);
        check("t4 abort rsp_candidate", 32'(rsp_candidate), 32'd0);
        check("t4 abort rsp_id", 32'(rsp_id), 32'd3);
        check("t4 engine still busy", 32'(set_busy), 32'd1);
        accept_rsp("t4");
        req_valid = 4'b0001;
        n = 0;
        while (set_busy && n < 60) begin
            #1;
            check("t4 no grant while busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("t4 engine went idle", 32'(set_busy), 32'd0);
        stub = 1'b0;
        wait_grant("t4 after drain", 0);
        req_valid = '0;
        wait_rsp("t4 after drain", 0, 29, 1'b0);
        accept_rsp("t4 after drain");

        // Test 5: reset during WAIT drops the job; a radius-2 job on req2 covers 13 points.
        req_valid = 4'b0010;
        wait_grant("t5", 1);
        req_valid = '0;
        @(negedge clk);
        pulse_reset();
        check("t5 rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5 set_en", 32'(set_en), 32'd0);
        check("t5 rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        check("t5 state", 32'(dut.state_q), 32'(ST_IDLE));
        req_radius[2*SET_RAD_W +: SET_RAD_W] = 12'h200;
        req_valid = 4'b0100;
        wait_grant("t5 fresh", 2);
        req_valid = '0;
        check("t5 set_radius", 32'(set_radius), 32'h200);
        wait_rsp("t5 fresh", 2, 13, 1'b0);
        accept_rsp("t5 fresh");

        // Test 6: wrap from rr_ptr=3, then req0 beats req1; req1 runs A&B with B inside A (5 points).
        check("t6 rr_ptr before", 32'(dut.rr_ptr_q), 32'd3);
        req_valid = 4'b1000;
        wait_grant("t6", 3);
        req_valid = '0;
        check("t6 rr_ptr wrap", 32'(dut.rr_ptr_q), 32'd0);
        wait_rsp("t6", 3, 29, 1'b0);
        accept_rsp("t6");
        req_central[1*SET_CENT_W +: SET_CENT_W] = 24'h444400;
        req_radius[1*SET_RAD_W +: SET_RAD_W]    = 12'h310;
        req_mode[1*SET_MODE_W +: SET_MODE_W]    = MODE_AND;
        req_valid = 4'b0011;
        wait_grant("t6 pair first", 0);
        req_valid = 4'b0010;
        wait_rsp("t6 pair first", 0, 29, 1'b0);
        accept_rsp("t6 pair first");
        wait_grant("t6 pair second", 1);
        req_valid = '0;
        check("t6 set_central", 32'(set_central), 32'h444400);
        check("t6 set_mode", 32'(set_mode), 32'(MODE_AND));
        wait_rsp("t6 pair second", 1, 5, 1'b0);
        accept_rsp("t6 pair second");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

endmodule
